// File: rtl/sigma_spi_tx.sv
// SPI mode-0 transmitter for 12-bit accumulator sums: 4-entry FIFO, 4-bit
// sequence tag prepended to each sum, 16-bit frames sent MSB first.
module sigma_spi_tx #(
    parameter int unsigned DIV = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic [11:0] data_in,
    input  logic        syn_in,
    input  logic        ovf_clr,
    output logic        sclk,
    output logic        cs_n,
    output logic        sdo,
    output logic        busy,
    output logic        overflow,
    output logic [2:0]  level
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_e;

    localparam logic [8:0] HALF        = 9'(DIV);
    localparam logic [8:0] PERIOD_LAST = 9'(2 * DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;
    logic [3:0]  tag_q, tag_d;
    logic        ovf_q, ovf_d;
    logic [8:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        sdo_q, sdo_d;
    logic        busy_q, busy_d;
    logic        pop, wr_en, drop;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tag_q    <= '0;
            ovf_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sdo_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (wr_en) fifo_q[wr_ptr_q] <= {tag_q, data_in};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tag_q    <= tag_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sdo_q    <= sdo_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;

        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        pop   = (state_q == IDLE) && (level_q != 3'd0);
        wr_en = syn_in && ((level_q != 3'd4) || pop);
        drop  = syn_in && !wr_en;

        tag_d = syn_in ? tag_q + 4'd1 : tag_q;
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        if (wr_en) wr_ptr_d = wr_ptr_q + 2'd1;
        if (wr_en && !pop)      level_d = level_q + 3'd1;
        else if (!wr_en && pop) level_d = level_q - 3'd1;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shreg_d  = fifo_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 2'd1;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == PERIOD_LAST) begin
                    div_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 9'd1;
                end
            end
            GAP: begin
                if (div_q == PERIOD_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 9'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state.
        sclk_d = (state_d == SHIFT) && (div_d >= HALF);
        cs_n_d = (state_d != SHIFT);
        sdo_d  = (state_d == SHIFT) ? shreg_d[15] : 1'b0;
        busy_d = (state_d != IDLE) || (level_d != 3'd0);
    end

    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign sdo      = sdo_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule

// File: tb/tb_sigma_spi_tx.sv
// Bench for sigma_spi_tx: a receiver model samples sdo on sclk rises and frames
// are compared with words predicted from the tag/data rules.
module tb_sigma_spi_tx;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [11:0] data_in = '0;
    logic        syn_in = 1'b0;
    logic        ovf_clr = 1'b0;

    logic sclk2, cs_n2, sdo2, busy2, ovf2;
    logic [2:0] level2;
    logic sclk1, cs_n1, sdo1, busy1, ovf1;
    logic [2:0] level1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sigma_spi_tx #(.DIV(2)) dut2 (
        .clk(clk), .res(res), .data_in(data_in), .syn_in(syn_in), .ovf_clr(ovf_clr),
        .sclk(sclk2), .cs_n(cs_n2), .sdo(sdo2), .busy(busy2), .overflow(ovf2), .level(level2)
    );

    sigma_spi_tx #(.DIV(1)) dut1 (
        .clk(clk), .res(res), .data_in(data_in), .syn_in(syn_in), .ovf_clr(ovf_clr),
        .sclk(sclk1), .cs_n(cs_n1), .sdo(sdo1), .busy(busy1), .overflow(ovf1), .level(level1)
    );

    // Reference model: expected frames and the free-running tag
    logic [15:0] exp_q[$];
    int          tag_m = 0;

    // Receiver models, one per instance
    logic [15:0] rx2[$], rx1[$];
    logic [15:0] sh2, sh1;
    int bits2 = 0, bits1 = 0, low2 = 0, low1 = 0, last_low2 = 0, last_low1 = 0;
    int bad2 = 0, bad1 = 0;
    logic sclk2_p = 1'b0, cs2_p = 1'b1, sclk1_p = 1'b0, cs1_p = 1'b1;

    always @(negedge clk) begin
        if (res) begin
            bits2 = 0; low2 = 0; sclk2_p = 1'b0; cs2_p = 1'b1;
        end else begin
            if (!cs_n2) begin
                low2++;
                if (sclk2 && !sclk2_p) begin sh2 = {sh2[14:0], sdo2}; bits2++; end
            end
            if (cs_n2 && !cs2_p) begin
                last_low2 = low2;
                if (bits2 == 16) rx2.push_back(sh2); else bad2++;
                bits2 = 0; low2 = 0;
            end
            sclk2_p = sclk2; cs2_p = cs_n2;
        end
    end

    always @(negedge clk) begin
        if (res) begin
            bits1 = 0; low1 = 0; sclk1_p = 1'b0; cs1_p = 1'b1;
        end else begin
            if (!cs_n1) begin
                low1++;
                if (sclk1 && !sclk1_p) begin sh1 = {sh1[14:0], sdo1}; bits1++; end
            end
            if (cs_n1 && !cs1_p) begin
                last_low1 = low1;
                if (bits1 == 16) rx1.push_back(sh1); else bad1++;
                bits1 = 0; low1 = 0;
            end
            sclk1_p = sclk1; cs1_p = cs_n1;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        res = 1'b1;
        syn_in = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rx2.delete(); rx1.delete(); exp_q.delete();
        tag_m = 0;
        res = 1'b0;
        @(negedge clk);
    endtask

    // One syn_in pulse sampled at the next rising edge; returns at the following negedge.
    task automatic send(input logic [11:0] d, input bit accept);
        logic [3:0] t;
        t = 4'(tag_m);
        data_in = d;
        syn_in = 1'b1;
        @(negedge clk);
        syn_in = 1'b0;
        if (accept) exp_q.push_back({t, d});
        tag_m = (tag_m + 1) % 16;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 * n + 200; c++) begin
            @(negedge clk);
            if (rx2.size() >= n && !busy2) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (sclk2 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b expected 0", sclk2); end
        checks++; if (cs_n2 !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b expected 1", cs_n2); end
        checks++; if (sdo2 !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b expected 0", sdo2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy2); end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", ovf2); end
        checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", level2); end
    endtask

    task automatic test_single();
        bit ok;
        logic [15:0] got;
        send(12'hA5C, 1'b1);
        checks++; if (level2 !== 3'd1) begin errors++; $display("FAIL single_level got %0d expected 1", level2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy2); end
        @(negedge clk);
        checks++; if (cs_n2 !== 1'b0) begin errors++; $display("FAIL single_cs_fall got %b expected 0", cs_n2); end
        checks++; if (sdo2 !== 1'b0) begin errors++; $display("FAIL single_first_bit got %b expected 0", sdo2); end
        @(negedge clk);
        checks++; if (sclk2 !== 1'b0) begin errors++; $display("FAIL single_sclk_low got %b expected 0", sclk2); end
        @(negedge clk);
        checks++; if (sclk2 !== 1'b1) begin errors++; $display("FAIL single_sclk_rise got %b expected 1", sclk2); end
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d frames expected 1", rx2.size()); end
        got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
        void'(exp_q.pop_front());
        checks++; if (got !== 16'h0A5C) begin errors++; $display("FAIL single_word got %h expected 0a5c", got); end
        checks++; if (last_low2 != 64) begin errors++; $display("FAIL single_cs_low got %0d expected 64", last_low2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b expected 0", busy2); end
    endtask

    task automatic test_negative();
        bit ok;
        logic [15:0] got;
        send(12'hF80, 1'b1);
        wait_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL negative_timeout got %0d frames expected 1", rx2.size()); end
        got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
        void'(exp_q.pop_front());
        checks++; if (got !== 16'h1F80) begin errors++; $display("FAIL negative_word got %h expected 1f80", got); end
    endtask

    task automatic test_tag_wrap();
        bit ok;
        logic [15:0] got, e;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            send(12'($urandom), 1'b1);
            wait_frames(1, ok);
            got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e) begin errors++; $display("FAIL wrap_word%0d got %h expected %h", i, got, e); end
            checks++;
            if (got[15:12] !== 4'(i % 16)) begin errors++; $display("FAIL wrap_tag%0d got %0d expected %0d", i, got[15:12], i % 16); end
        end
    endtask

    task automatic test_burst();
        bit ok;
        logic [15:0] got, e;
        apply_reset();
        for (int i = 0; i < 5; i++) send(12'($urandom), 1'b1);
        checks++; if (level2 !== 3'd4) begin errors++; $display("FAIL burst_level_full got %0d expected 4", level2); end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL burst_ovf_early got %b expected 0", ovf2); end
        send(12'($urandom), 1'b0);
        checks++; if (level2 !== 3'd4) begin errors++; $display("FAIL burst_level_drop got %0d expected 4", level2); end
        checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL burst_ovf_set got %b expected 1", ovf2); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL burst_ovf_clr got %b expected 0", ovf2); end
        wait_frames(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got %0d frames expected 5", rx2.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
            e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL burst_word%0d got %h expected %h", i, got, e); end
        end
        send(12'($urandom), 1'b1);
        wait_frames(1, ok);
        got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
        e = exp_q.pop_front();
        checks++; if (!ok || got !== e) begin errors++; $display("FAIL burst_next got %h expected %h", got, e); end
        checks++; if (got[15:12] !== 4'd6) begin errors++; $display("FAIL burst_next_tag got %0d expected 6", got[15:12]); end
    endtask

    // First pop at edge n+1, second at n+1+34*DIV+1 = n+70 for DIV=2.
    task automatic test_full_pop();
        bit ok;
        logic [15:0] got, e;
        apply_reset();
        for (int i = 0; i < 5; i++) send(12'($urandom), 1'b1);
        repeat (65) @(negedge clk);
        checks++; if (level2 !== 3'd4 || cs_n2 !== 1'b1) begin errors++; $display("FAIL fullpop_pre got level %0d cs_n %b expected 4 1", level2, cs_n2); end
        send(12'($urandom), 1'b1);
        checks++; if (level2 !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d expected 4", level2); end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b expected 0", ovf2); end
        checks++; if (cs_n2 !== 1'b0) begin errors++; $display("FAIL fullpop_cs got %b expected 0", cs_n2); end
        wait_frames(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fullpop_timeout got %0d frames expected 6", rx2.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
            e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL fullpop_word%0d got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [15:0] got, e;
        apply_reset();
        send(12'($urandom), 1'b1);
        send(12'($urandom), 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bits2 == 7) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL midreset_reach got %0d bits expected 7", bits2); end
        checks++; if (level2 !== 3'd1) begin errors++; $display("FAIL midreset_pre_level got %0d expected 1", level2); end
        #2 res = 1'b1;
        #1;
        checks++; if (cs_n2 !== 1'b1) begin errors++; $display("FAIL midreset_cs got %b expected 1", cs_n2); end
        checks++; if (sclk2 !== 1'b0) begin errors++; $display("FAIL midreset_sclk got %b expected 0", sclk2); end
        checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL midreset_level got %0d expected 0", level2); end
        @(negedge clk);
        checks++; if (rx2.size() != 0) begin errors++; $display("FAIL midreset_aborted got %0d frames expected 0", rx2.size()); end
        apply_reset();
        send(12'($urandom), 1'b1);
        wait_frames(1, ok);
        got = (rx2.size() > 0) ? rx2.pop_front() : 'x;
        e = exp_q.pop_front();
        checks++; if (!ok || got !== e) begin errors++; $display("FAIL midreset_next got %h expected %h", got, e); end
        checks++; if (got[15:12] !== 4'd0) begin errors++; $display("FAIL midreset_tag got %0d expected 0", got[15:12]); end
    endtask

    task automatic test_div1();
        bit ok;
        logic [15:0] got;
        apply_reset();
        send(12'hA5C, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rx1.size() > 0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL div1_timeout got %0d frames expected 1", rx1.size()); end
        got = (rx1.size() > 0) ? rx1.pop_front() : 'x;
        checks++; if (got !== 16'h0A5C) begin errors++; $display("FAIL div1_word got %h expected 0a5c", got); end
        checks++; if (last_low1 != 32) begin errors++; $display("FAIL div1_cs_low got %0d expected 32", last_low1); end
        wait_frames(1, ok);
    endtask

    task automatic test_framing();
        checks++; if (bad2 != 0) begin errors++; $display("FAIL framing_div2 got %0d short frames expected 0", bad2); end
        checks++; if (bad1 != 0) begin errors++; $display("FAIL framing_div1 got %0d short frames expected 0", bad1); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_tag_wrap();
        test_burst();
        test_full_pop();
        test_reset_mid();
        test_div1();
        test_framing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigma_spi_tx.md
# sigma_spi_tx

Downstream consumer of the 16-point accumulator stage. It captures each 12-bit two's-complement sum on its one-cycle sync pulse and buffers it in a 4-entry FIFO. Each sum is sent off-chip as a 16-bit SPI (mode 0) frame: a 4-bit sequence tag followed by the sum. The tag lets the receiver detect dropped sums.

## Interface
- `DIV`, default 2: half-period of `sclk` in `clk` cycles; legal range 1..255.
- `clk`  in  1: system clock; all logic on the rising edge.
- `res`  in  1: asynchronous, active-high reset.
- `data_in`  in  12: accumulated sum, two's complement; valid when `syn_in`=1.
- `syn_in`  in  1: one-cycle strobe marking a new sum.
- `ovf_clr`  in  1: synchronous clear of `overflow`.
- `sclk`  out  1: serial clock; idles low.
- `cs_n`  out  1: frame select, active low.
- `sdo`  out  1: serial data, MSB first.
- `busy`  out  1: 1 when the FSM is not IDLE or the FIFO is not empty.
- `overflow`  out  1: sticky flag; a sum was dropped because the FIFO was full.
- `level`  out  3: FIFO occupancy, 0..4.

## Operation
- Word format: `{tag[3:0], data_in[11:0]}`.
  - `tag` is a 4-bit counter.
  - It increments on every `syn_in`, including dropped sums, and wraps 15→0.
  - The first accepted sum after reset carries tag 0.
- FIFO: 4 × 16 bits, with write pointer, read pointer and `level`.
  - Write is accepted when `level`<4, or when a pop occurs in the same cycle.
  - Otherwise the word is discarded and `overflow` is set to 1.
- `overflow` clear:
  - `ovf_clr`=1 clears `overflow`.
  - A drop in the same cycle wins, so `overflow` stays 1.
- Simultaneous write and pop: `level` is unchanged, and both pointers advance.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=0. If `level`>0, pop the head word into the 16-bit shift register and go to SHIFT.
  - SHIFT: `cs_n`=0. 16 bit periods of 2·`DIV` clocks each, counted by a divider counter and a 4-bit bit counter.
    - First half of each period: `sclk`=0, and `sdo` holds the current bit.
    - Second half: `sclk`=1.
    - Shifting and the bit change happen on the `sclk` falling edge.
    - After the 16th period go to GAP.
  - GAP: `cs_n`=1, `sclk`=0, `sdo`=0 for 2·`DIV` clocks, then go to IDLE.
- Receiver sampling: the receiver samples `sdo` on the `sclk` rising edge. Bit order is tag[3] first, data[0] last.
- Outputs are registered; no combinational path from inputs to `sclk`/`cs_n`/`sdo`.

## Timing
- Reset values:
  - Outputs: `sclk`=0, `cs_n`=1, `sdo`=0, `busy`=0, `overflow`=0, `level`=0.
  - Internal: `tag`=0, FIFO pointers 0, FSM in IDLE.
- Reset mid-frame aborts the frame immediately, asynchronously: `cs_n` goes high and the FIFO contents are lost.
- Latency from an empty, idle block:
  - `syn_in` sampled at edge n → `level`=1 after edge n.
  - Pop happens at edge n+1; `cs_n`=0 and `sdo`=tag[3] after edge n+1.
  - The first `sclk` rise is after edge n+1+`DIV`.
- Frame timing:
  - `cs_n` stays low for exactly 32·`DIV` clocks.
  - Frame-to-frame spacing when the FIFO is non-empty is 34·`DIV`+1 clocks (SHIFT + GAP + 1 IDLE cycle).
- The `syn_in` interval must exceed 34·`DIV`+1 clocks on average. Bursts of up to 4 sums are absorbed by the FIFO.

## Test plan
- Single sum, `DIV`=2: `data_in`=12'hA5C with one `syn_in` pulse.
  - `cs_n` falls 2 edges later and stays low 64 clocks.
  - Bits sampled on `sclk` rises read 16'h0A5C.
  - `busy` returns to 0 after GAP.
- Negative sum: `data_in`=12'hF80 (−128) as the 2nd word → frame 16'h1F80.
- Burst: 6 `syn_in` pulses on consecutive cycles during idle.
  - 1st sum is popped, next 4 fill the FIFO (`level`=4), 6th is dropped, `overflow`=1.
  - Transmitted tags are 0,1,2,3,4; the next accepted sum carries tag 6.
  - `ovf_clr` then clears the flag.
- Full FIFO with a `syn_in` in the exact cycle IDLE pops: write is accepted, `level` stays 4, `overflow` stays 0.
- Tag wrap: 17 spaced sums → tags 0..15, then 0.
- Reset asserted mid-frame at bit 7: `cs_n`=1, `sclk`=0, `level`=0 immediately. After release, the next sum is sent with tag 0. Repeat the single-sum case with `DIV`=1 to check 32-clock `cs_n` low.
